// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
//   ID/EX pipeline register plus the operand-select logic that feeds the ALU.
//   Captures decoded ID fields, resolves RAW hazards and raises a one-cycle
//   load-use stall while a bubble is injected into EX.
//
// Configuration macro: ID_EX_FWD_EN
//   defined   : MEM/WB forwarding muxes; load_use_stall covers loads in EX only.
//   undefined : no forwarding, operands come straight from the registered
//               read values; load_use_stall fires on any RAW against a
//               writing instruction in EX or MEM (WB is covered by the
//               register file's write-first behaviour).
module id_ex_operand_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               id_valid,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [XLEN-1:0]    id_rs1_val,
  input  logic [XLEN-1:0]    id_rs2_val,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [RADDR_W-1:0] id_rs1_addr,
  input  logic [RADDR_W-1:0] id_rs2_addr,
  input  logic [RADDR_W-1:0] id_rd_addr,
  input  logic [3:0]         id_alu_ctrl,
  input  logic               id_src_a_pc,
  input  logic               id_src_b_imm,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic [RADDR_W-1:0] mem_rd_addr,
  input  logic               mem_reg_write,
  input  logic [XLEN-1:0]    mem_result,
  input  logic [RADDR_W-1:0] wb_rd_addr,
  input  logic               wb_reg_write,
  input  logic [XLEN-1:0]    wb_result,
  output logic [XLEN-1:0]    alu_a,
  output logic [XLEN-1:0]    alu_b,
  output logic [3:0]         alu_ctrl,
  output logic [XLEN-1:0]    ex_store_data,
  output logic               ex_valid,
  output logic [RADDR_W-1:0] ex_rd_addr,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               load_use_stall
);

  localparam logic [RADDR_W-1:0] REG_X0 = {RADDR_W{1'b0}};

  // Registered ID/EX fields
  logic               valid_q,     valid_d;
  logic [XLEN-1:0]    pc_q,        pc_d;
  logic [XLEN-1:0]    rs1_val_q,   rs1_val_d;
  logic [XLEN-1:0]    rs2_val_q,   rs2_val_d;
  logic [XLEN-1:0]    imm_q,       imm_d;
  logic [RADDR_W-1:0] rs1_addr_q,  rs1_addr_d;
  logic [RADDR_W-1:0] rs2_addr_q,  rs2_addr_d;
  logic [RADDR_W-1:0] rd_addr_q,   rd_addr_d;
  logic [3:0]         alu_ctrl_q,  alu_ctrl_d;
  logic               src_a_pc_q,  src_a_pc_d;
  logic               src_b_imm_q, src_b_imm_d;
  logic               reg_write_q, reg_write_d;
  logic               mem_read_q,  mem_read_d;

  // Combinational hazard / operand signals
  logic               id_uses_ex_rd_s;
  logic               load_use_s;
  logic [XLEN-1:0]    fwd_rs1_s;
  logic [XLEN-1:0]    fwd_rs2_s;

  // A producer matches a source only when it writes a nonzero register.
  function automatic logic rd_hits_src(input logic               we,
                                       input logic [RADDR_W-1:0] rd,
                                       input logic [RADDR_W-1:0] src);
    return we && (rd != REG_X0) && (rd == src);
  endfunction

  // Does the instruction in ID read the register the EX instruction writes
  always_comb begin
    id_uses_ex_rd_s = 1'b0;
    if (rd_addr_q != REG_X0) begin
      id_uses_ex_rd_s = (id_rs1_addr == rd_addr_q) || (id_rs2_addr == rd_addr_q);
    end else begin
      id_uses_ex_rd_s = 1'b0;
    end
  end

`ifdef ID_EX_FWD_EN

  // Only a load in EX produces its value too late to be forwarded
  always_comb begin
    load_use_s = 1'b0;
    if (flush_i) begin
      load_use_s = 1'b0;
    end else begin
      load_use_s = valid_q && mem_read_q && id_valid && id_uses_ex_rd_s;
    end
  end

  // Forwarding muxes: MEM has priority over WB, x0 is never forwarded
  always_comb begin
    fwd_rs1_s = rs1_val_q;
    fwd_rs2_s = rs2_val_q;
    if (rd_hits_src(mem_reg_write, mem_rd_addr, rs1_addr_q)) begin
      fwd_rs1_s = mem_result;
    end else if (rd_hits_src(wb_reg_write, wb_rd_addr, rs1_addr_q)) begin
      fwd_rs1_s = wb_result;
    end else begin
      fwd_rs1_s = rs1_val_q;
    end
    if (rd_hits_src(mem_reg_write, mem_rd_addr, rs2_addr_q)) begin
      fwd_rs2_s = mem_result;
    end else if (rd_hits_src(wb_reg_write, wb_rd_addr, rs2_addr_q)) begin
      fwd_rs2_s = wb_result;
    end else begin
      fwd_rs2_s = rs2_val_q;
    end
  end

`else

  logic id_uses_mem_rd_s;
  logic unused_fwd_inputs_s;

  // Without forwarding the data paths of MEM/WB are not consumed here
  assign unused_fwd_inputs_s = ^{mem_result, wb_rd_addr, wb_reg_write, wb_result};

  // Any RAW against a writing instruction in EX or MEM must stall
  always_comb begin
    id_uses_mem_rd_s = 1'b0;
    load_use_s       = 1'b0;
    id_uses_mem_rd_s = rd_hits_src(mem_reg_write, mem_rd_addr, id_rs1_addr) ||
                       rd_hits_src(mem_reg_write, mem_rd_addr, id_rs2_addr);
    if (flush_i) begin
      load_use_s = 1'b0;
    end else begin
      load_use_s = id_valid &&
                   ((valid_q && reg_write_q && id_uses_ex_rd_s) || id_uses_mem_rd_s);
    end
  end

  // Operands come straight from the registered read values
  always_comb begin
    fwd_rs1_s = rs1_val_q;
    fwd_rs2_s = rs2_val_q;
  end

`endif

  // Next-state select: flush > stall (hold) > load-use bubble > capture
  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1_val_d   = rs1_val_q;
    rs2_val_d   = rs2_val_q;
    imm_d       = imm_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rd_addr_d   = rd_addr_q;
    alu_ctrl_d  = alu_ctrl_q;
    src_a_pc_d  = src_a_pc_q;
    src_b_imm_d = src_b_imm_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    if (flush_i || (!stall_i && load_use_s)) begin
      // Bubble: everything cleared so the empty stage drives zero operands
      valid_d     = 1'b0;
      pc_d        = {XLEN{1'b0}};
      rs1_val_d   = {XLEN{1'b0}};
      rs2_val_d   = {XLEN{1'b0}};
      imm_d       = {XLEN{1'b0}};
      rs1_addr_d  = REG_X0;
      rs2_addr_d  = REG_X0;
      rd_addr_d   = REG_X0;
      alu_ctrl_d  = 4'b0000;
      src_a_pc_d  = 1'b0;
      src_b_imm_d = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
    end else if (stall_i) begin
      // Hold: defaults already keep the current contents
      valid_d     = valid_q;
    end else begin
      valid_d     = id_valid;
      pc_d        = id_pc;
      rs1_val_d   = id_rs1_val;
      rs2_val_d   = id_rs2_val;
      imm_d       = id_imm;
      rs1_addr_d  = id_rs1_addr;
      rs2_addr_d  = id_rs2_addr;
      rd_addr_d   = id_rd_addr;
      alu_ctrl_d  = id_alu_ctrl;
      src_a_pc_d  = id_src_a_pc;
      src_b_imm_d = id_src_b_imm;
      reg_write_d = id_reg_write;
      mem_read_d  = id_mem_read;
    end
  end

  // ID/EX register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      pc_q        <= {XLEN{1'b0}};
      rs1_val_q   <= {XLEN{1'b0}};
      rs2_val_q   <= {XLEN{1'b0}};
      imm_q       <= {XLEN{1'b0}};
      rs1_addr_q  <= REG_X0;
      rs2_addr_q  <= REG_X0;
      rd_addr_q   <= REG_X0;
      alu_ctrl_q  <= 4'b0000;
      src_a_pc_q  <= 1'b0;
      src_b_imm_q <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_val_q   <= rs1_val_d;
      rs2_val_q   <= rs2_val_d;
      imm_q       <= imm_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rd_addr_q   <= rd_addr_d;
      alu_ctrl_q  <= alu_ctrl_d;
      src_a_pc_q  <= src_a_pc_d;
      src_b_imm_q <= src_b_imm_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
    end
  end

  // Final ALU operand selection
  always_comb begin
    alu_a         = fwd_rs1_s;
    alu_b         = fwd_rs2_s;
    ex_store_data = fwd_rs2_s;
    if (src_a_pc_q) begin
      alu_a = pc_q;
    end else begin
      alu_a = fwd_rs1_s;
    end
    if (src_b_imm_q) begin
      alu_b = imm_q;
    end else begin
      alu_b = fwd_rs2_s;
    end
  end

  assign alu_ctrl       = alu_ctrl_q;
  assign ex_valid       = valid_q;
  assign ex_rd_addr     = rd_addr_q;
  assign ex_reg_write   = reg_write_q;
  assign ex_mem_read    = mem_read_q;
  assign load_use_stall = load_use_s;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: table-driven vectors with a reference model and a
// scoreboard queue of expected EX-stage contents, plus hand-written sequences
// for reset, forwarding, load-use, flush/stall and stall-hold behaviour.
module tb_id_ex_operand_stage;

  typedef struct packed {
    logic        rst, stall, flush, idv;
    logic [31:0] pc, rs1v, rs2v, imm;
    logic [4:0]  rs1a, rs2a, rd;
    logic [3:0]  ctrl;
    logic        srca, srcb, rw, mr;
    logic [4:0]  mrd;
    logic        mrw;
    logic [31:0] mres;
    logic [4:0]  wrd;
    logic        wrw;
    logic [31:0] wres;
  } vec_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1v, rs2v, imm;
    logic [4:0]  rs1a, rs2a, rd;
    logic [3:0]  ctrl;
    logic        srca, srcb, rw, mr;
  } st_t;

  logic        clk, reset, stall_i, flush_i, id_valid;
  logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [3:0]  id_alu_ctrl;
  logic        id_src_a_pc, id_src_b_imm, id_reg_write, id_mem_read;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_result, wb_result;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_ctrl;
  logic        ex_valid, ex_reg_write, ex_mem_read, load_use_stall;
  logic [4:0]  ex_rd_addr;

  int   n_vec = 0;
  int   n_err = 0;
  st_t  m;
  st_t  sb[$];
  vec_t cur_v;
  logic known = 1'b0;

  id_ex_operand_stage #(.XLEN(32), .RADDR_W(5)) dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_val(id_rs1_val),
    .id_rs2_val(id_rs2_val), .id_imm(id_imm), .id_rs1_addr(id_rs1_addr),
    .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr), .id_alu_ctrl(id_alu_ctrl),
    .id_src_a_pc(id_src_a_pc), .id_src_b_imm(id_src_b_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .ex_store_data(ex_store_data),
    .ex_valid(ex_valid), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .load_use_stall(load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic hit(input logic we, input logic [4:0] rd, input logic [4:0] src);
    return we && (rd != 5'd0) && (rd == src);
  endfunction

  function automatic logic [31:0] m_opnd(input logic [4:0] src, input logic [31:0] regval,
                                         input vec_t v);
`ifdef ID_EX_FWD_EN
    if (hit(v.mrw, v.mrd, src)) return v.mres;
    if (hit(v.wrw, v.wrd, src)) return v.wres;
`endif
    return regval;
  endfunction

  function automatic logic m_lus(input st_t s, input vec_t v);
    logic ex_hit, mem_hit;
    if (v.flush || !v.idv) return 1'b0;
    ex_hit  = (s.rd != 5'd0) && ((v.rs1a == s.rd) || (v.rs2a == s.rd));
    mem_hit = hit(v.mrw, v.mrd, v.rs1a) || hit(v.mrw, v.mrd, v.rs2a);
`ifdef ID_EX_FWD_EN
    return s.valid && s.mr && ex_hit;
`else
    return (s.valid && s.rw && ex_hit) || mem_hit;
`endif
  endfunction

  function automatic st_t m_next(input st_t s, input vec_t v, input logic lus);
    st_t n;
    n = '0;
    if (v.rst || v.flush) return n;
    if (v.stall) return s;
    if (lus) return n;
    n.valid = v.idv;  n.pc = v.pc;     n.rs1v = v.rs1v; n.rs2v = v.rs2v;
    n.imm   = v.imm;  n.rs1a = v.rs1a; n.rs2a = v.rs2a; n.rd = v.rd;
    n.ctrl  = v.ctrl; n.srca = v.srca; n.srcb = v.srcb; n.rw = v.rw; n.mr = v.mr;
    return n;
  endfunction

  function automatic vec_t idle();
    vec_t v;
    v = '0;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v = '0;
    v.rst   = ($urandom_range(0, 15) == 0);
    v.stall = ($urandom_range(0, 4) == 0);
    v.flush = ($urandom_range(0, 5) == 0);
    v.idv   = $urandom_range(0, 1);
    v.pc = $urandom; v.rs1v = $urandom; v.rs2v = $urandom; v.imm = $urandom;
    v.rs1a = 5'($urandom_range(0, 3)); v.rs2a = 5'($urandom_range(0, 3));
    v.rd   = 5'($urandom_range(0, 3)); v.ctrl = 4'($urandom_range(0, 9));
    v.srca = $urandom_range(0, 1); v.srcb = $urandom_range(0, 1);
    v.rw   = $urandom_range(0, 1); v.mr   = $urandom_range(0, 1);
    v.mrd  = 5'($urandom_range(0, 3)); v.mrw = $urandom_range(0, 1); v.mres = $urandom;
    v.wrd  = 5'($urandom_range(0, 3)); v.wrw = $urandom_range(0, 1); v.wres = $urandom;
    return v;
  endfunction

  // ---------------- drive / compare ----------------
  task automatic drive(input vec_t v);
    reset = v.rst; stall_i = v.stall; flush_i = v.flush; id_valid = v.idv;
    id_pc = v.pc; id_rs1_val = v.rs1v; id_rs2_val = v.rs2v; id_imm = v.imm;
    id_rs1_addr = v.rs1a; id_rs2_addr = v.rs2a; id_rd_addr = v.rd; id_alu_ctrl = v.ctrl;
    id_src_a_pc = v.srca; id_src_b_imm = v.srcb; id_reg_write = v.rw; id_mem_read = v.mr;
    mem_rd_addr = v.mrd; mem_reg_write = v.mrw; mem_result = v.mres;
    wb_rd_addr = v.wrd; wb_reg_write = v.wrw; wb_result = v.wres;
  endtask

  task automatic comb_cmp(input vec_t v);
    logic [31:0] f2;
    if (known) begin
      f2 = m_opnd(m.rs2a, m.rs2v, v);
      chk("alu_a", alu_a, m.srca ? m.pc : m_opnd(m.rs1a, m.rs1v, v));
      chk("alu_b", alu_b, m.srcb ? m.imm : f2);
      chk("store_data", ex_store_data, f2);
      chk("load_use_stall", {31'd0, load_use_stall}, {31'd0, m_lus(m, v)});
    end
  endtask

  task automatic drive_cmp(input vec_t v);
    @(negedge clk);
    drive(v);
    cur_v = v;
    #1;
    comb_cmp(v);
    sb.push_back(m_next(m, v, m_lus(m, v)));
  endtask

  task automatic edge_cmp();
    st_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard: got empty queue, expected one entry");
    end else begin
      e = sb.pop_front();
      chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
      chk("ex_rd_addr", {27'd0, ex_rd_addr}, {27'd0, e.rd});
      chk("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, e.rw});
      chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, e.mr});
      chk("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, e.ctrl});
      m = e;
      known = 1'b1;
      comb_cmp(cur_v);
    end
  endtask

  task automatic apply(input vec_t v);
    drive_cmp(v);
    edge_cmp();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t tbl[20];
    vec_t v, ins, lw, dep;
    m = '0;
    drive(idle());

    // Vector table: directed corner cases first, random patterns after
    tbl[0] = idle(); tbl[0].idv = 1'b1; tbl[0].srca = 1'b1; tbl[0].pc = 32'h0000_1000;
    tbl[0].srcb = 1'b1; tbl[0].imm = 32'hFFFF_FFF0; tbl[0].rs1a = 5'd1; tbl[0].rs2a = 5'd2;
    tbl[0].rd = 5'd3; tbl[0].rw = 1'b1; tbl[0].ctrl = 4'd2; tbl[0].rs2v = 32'h0000_0042;
    tbl[1] = idle(); tbl[1].mrd = 5'd2; tbl[1].mrw = 1'b1; tbl[1].mres = 32'h0000_BEEF;
    tbl[1].wrd = 5'd1; tbl[1].wrw = 1'b1; tbl[1].wres = 32'h0000_CAFE;
    tbl[2] = idle(); tbl[2].idv = 1'b1; tbl[2].mr = 1'b1; tbl[2].rw = 1'b1;
    tbl[2].rd = 5'd2; tbl[2].rs1a = 5'd1; tbl[2].rs1v = 32'h0000_0200;
    tbl[3] = idle(); tbl[3].idv = 1'b1; tbl[3].rs1a = 5'd2; tbl[3].rd = 5'd3;
    tbl[3].rw = 1'b1; tbl[3].stall = 1'b1;
    tbl[4] = tbl[3]; tbl[4].stall = 1'b0;
    tbl[5] = tbl[3]; tbl[5].stall = 1'b0; tbl[5].rst = 1'b1;
    for (int i = 6; i < 20; i++) tbl[i] = rand_vec();

    // 1. Reset for two cycles with random ID inputs
    for (int i = 0; i < 2; i++) begin
      v = rand_vec(); v.rst = 1'b1; v.mrw = 1'b0;
      apply(v);
    end
    chk("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    chk("reset_alu_a", alu_a, 32'd0);
    chk("reset_alu_b", alu_b, 32'd0);
    chk("reset_load_use", {31'd0, load_use_stall}, 32'd0);

    // 2. MEM forward onto rs1 of add x5
    ins = idle(); ins.idv = 1'b1; ins.rs1a = 5'd5; ins.rs1v = 32'd1; ins.rs2a = 5'd2;
    ins.rs2v = 32'd3; ins.rd = 5'd8; ins.rw = 1'b1;
    apply(ins);
    v = idle(); v.mrd = 5'd5; v.mrw = 1'b1; v.mres = 32'h0000_0064;
    drive_cmp(v);
`ifdef ID_EX_FWD_EN
    chk("mem_fwd_alu_a", alu_a, 32'h0000_0064);
`else
    chk("mem_fwd_alu_a", alu_a, 32'h0000_0001);
`endif
    edge_cmp();

    // 3. MEM over WB priority, then x0 never forwarded
    ins = idle(); ins.idv = 1'b1; ins.rs2a = 5'd6; ins.rs2v = 32'h0000_0033;
    ins.rd = 5'd9; ins.rw = 1'b1; ins.ctrl = 4'b0111;
    apply(ins);
    v = idle(); v.mrd = 5'd6; v.mrw = 1'b1; v.mres = 32'h0000_0010;
    v.wrd = 5'd6; v.wrw = 1'b1; v.wres = 32'h0000_0020;
    drive_cmp(v);
`ifdef ID_EX_FWD_EN
    chk("mem_over_wb_alu_b", alu_b, 32'h0000_0010);
`else
    chk("mem_over_wb_alu_b", alu_b, 32'h0000_0033);
`endif
    edge_cmp();
    ins = idle(); ins.idv = 1'b1; ins.rs1a = 5'd6; ins.rs1v = 32'h0000_0044; ins.rw = 1'b1;
    apply(ins);
    v = idle(); v.mrd = 5'd0; v.mrw = 1'b1; v.mres = 32'h0000_00AA;
    v.wrd = 5'd0; v.wrw = 1'b1; v.wres = 32'h0000_00BB;
    drive_cmp(v);
    chk("x0_alu_b", alu_b, 32'd0);
    edge_cmp();

    // 4. Load-use: lw x7 in EX, dependent reads x7 via rs2
    lw = idle(); lw.idv = 1'b1; lw.rs1a = 5'd1; lw.rs1v = 32'h0000_0100; lw.srcb = 1'b1;
    lw.imm = 32'd4; lw.rd = 5'd7; lw.rw = 1'b1; lw.mr = 1'b1;
    dep = idle(); dep.idv = 1'b1; dep.rs1a = 5'd3; dep.rs1v = 32'd5; dep.rs2a = 5'd7;
    dep.rs2v = 32'd9; dep.rd = 5'd10; dep.rw = 1'b1; dep.ctrl = 4'b0001;
    apply(lw);
    drive_cmp(dep);
    chk("lu_stall_high", {31'd0, load_use_stall}, 32'd1);
    edge_cmp();
    chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    drive_cmp(dep);
    chk("lu_stall_low", {31'd0, load_use_stall}, 32'd0);
    edge_cmp();
    chk("lu_dep_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_dep_rd", {27'd0, ex_rd_addr}, 32'd10);

    // 5. Flush and stall together: flush wins, no stall during flush
    apply(lw);
    v = dep; v.flush = 1'b1; v.stall = 1'b1;
    drive_cmp(v);
    chk("flush_no_stall", {31'd0, load_use_stall}, 32'd0);
    edge_cmp();
    chk("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_reg_write", {31'd0, ex_reg_write}, 32'd0);

    // 6. Stall hold for three cycles while ID changes
    ins = idle(); ins.idv = 1'b1; ins.pc = 32'h0000_2000; ins.srca = 1'b1; ins.rs2a = 5'd4;
    ins.rs2v = 32'h0000_0077; ins.rd = 5'd12; ins.rw = 1'b1; ins.ctrl = 4'b1001;
    apply(ins);
    for (int i = 0; i < 3; i++) begin
      v = rand_vec(); v.rst = 1'b0; v.flush = 1'b0; v.stall = 1'b1;
      apply(v);
      chk("hold_valid", {31'd0, ex_valid}, 32'd1);
      chk("hold_rd", {27'd0, ex_rd_addr}, 32'd12);
      chk("hold_ctrl", {28'd0, alu_ctrl}, 32'd9);
      chk("hold_alu_a", alu_a, 32'h0000_2000);
    end

    // Table-driven vectors
    for (int i = 0; i < 20; i++) apply(tbl[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
